// File: rtl/spike_encoder.sv
// spike_encoder: rate-codes a latched image into P_NUM_TIMESTEPS spike frames,
// P_LANES pixels per cycle, each lane comparing its pixel against its own LFSR.
// Ports: clk, rst_n (async, active-low); i_image_buffer/i_image_valid image load;
//        i_encode_start run trigger; i_spike_ready frame accept;
//        o_spike_vec/o_spike_valid/o_timestep frame out; o_encode_busy/o_encode_done.
// Option: define SPIKE_ENCODER_RESEED_EN to reload every LFSR seed at run start.
module spike_encoder #(
    parameter int          P_NUM_INPUT_PIXELS     = 784,
    parameter int          P_PIXEL_INTENSITY_BITS = 8,
    parameter int          P_LANES                = 8,
    parameter int          P_NUM_TIMESTEPS        = 16,
    parameter logic [15:0] P_LFSR_SEED            = 16'hACE1,
    localparam int TS_W = (P_NUM_TIMESTEPS > 1) ? $clog2(P_NUM_TIMESTEPS) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic [P_NUM_INPUT_PIXELS-1:0][P_PIXEL_INTENSITY_BITS-1:0] i_image_buffer,
    input  logic i_image_valid,
    input  logic i_encode_start,
    input  logic i_spike_ready,
    output logic [P_NUM_INPUT_PIXELS-1:0] o_spike_vec,
    output logic o_spike_valid,
    output logic [TS_W-1:0] o_timestep,
    output logic o_encode_busy,
    output logic o_encode_done
);

    localparam int NCHUNK = P_NUM_INPUT_PIXELS / P_LANES;
    localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int IW = $clog2(P_NUM_INPUT_PIXELS);
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);
    localparam logic [TS_W-1:0] LAST_TS = TS_W'(P_NUM_TIMESTEPS - 1);

    typedef enum logic [1:0] {IDLE, ENCODE, PRESENT, DONE} state_t;

    state_t state;
    logic [CW-1:0] chunk;
    logic [P_NUM_INPUT_PIXELS-1:0][P_PIXEL_INTENSITY_BITS-1:0] img_buf;
    logic [P_NUM_INPUT_PIXELS-1:0] frame;
    logic [P_NUM_INPUT_PIXELS-1:0] frame_next;
    logic [15:0] lfsr [P_LANES];

    // Buffer index is reversed raster order: raster pixel 0 sits at the MSB.
    function automatic logic [IW-1:0] pix_idx(input logic [CW-1:0] k, input int j);
        return IW'(P_NUM_INPUT_PIXELS - 1 - P_LANES * int'(k) - j);
    endfunction

    // Right-shifting Fibonacci form, taps 16,14,13,11 -> bits 0,2,3,5.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    function automatic logic [15:0] lane_seed(input int j);
        return P_LFSR_SEED + 16'(j);
    endfunction

    // Current chunk merged into the frame, using pre-advance LFSR values.
    always_comb begin
        frame_next = frame;
        for (int j = 0; j < P_LANES; j++) begin
            frame_next[pix_idx(chunk, j)] =
                img_buf[pix_idx(chunk, j)] > lfsr[j][7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            chunk         <= '0;
            o_timestep    <= '0;
            img_buf       <= '0;
            frame         <= '0;
            o_spike_vec   <= '0;
            o_spike_valid <= 1'b0;
            o_encode_busy <= 1'b0;
            o_encode_done <= 1'b0;
            for (int j = 0; j < P_LANES; j++) begin
                lfsr[j] <= lane_seed(j);
            end
        end else begin
            o_encode_done <= 1'b0;
            if (i_image_valid && !o_encode_busy) begin
                img_buf <= i_image_buffer;
            end
            unique case (state)
                IDLE: begin
                    if (i_encode_start) begin
                        state         <= ENCODE;
                        chunk         <= '0;
                        o_timestep    <= '0;
                        o_encode_busy <= 1'b1;
`ifdef SPIKE_ENCODER_RESEED_EN
                        for (int j = 0; j < P_LANES; j++) begin
                            lfsr[j] <= lane_seed(j);
                        end
`endif
                    end
                end
                ENCODE: begin
                    frame <= frame_next;
                    for (int j = 0; j < P_LANES; j++) begin
                        lfsr[j] <= lfsr_step(lfsr[j]);
                    end
                    if (chunk == LAST_CHUNK) begin
                        state         <= PRESENT;
                        o_spike_vec   <= frame_next;
                        o_spike_valid <= 1'b1;
                    end else begin
                        chunk <= chunk + 1'b1;
                    end
                end
                PRESENT: begin
                    if (i_spike_ready) begin
                        o_spike_valid <= 1'b0;
                        if (o_timestep == LAST_TS) begin
                            state <= DONE;
                        end else begin
                            o_timestep <= o_timestep + 1'b1;
                            chunk      <= '0;
                            state      <= ENCODE;
                        end
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    o_encode_done <= 1'b1;
                    o_encode_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spike_encoder.sv
// tb_spike_encoder: randomized self-checking bench for spike_encoder,
// compared against a pixel-by-pixel rate-coding reference model.
module tb_spike_encoder;

    localparam int N    = 784;
    localparam int L    = 8;
    localparam int T    = 16;
    localparam int SEED = 16'hACE1;
    localparam int LAT  = N / L;

    typedef logic [N-1:0] wide_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0][7:0] i_image_buffer = '0;
    logic i_image_valid = 1'b0;
    logic i_encode_start = 1'b0;
    logic i_spike_ready = 1'b0;
    logic [N-1:0] o_spike_vec;
    logic o_spike_valid;
    logic [3:0] o_timestep;
    logic o_encode_busy;
    logic o_encode_done;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    logic [7:0] mdl_img [N];
    int mdl_lfsr [L];

    always #5 clk = ~clk;

    always @(negedge clk) if (o_encode_done) done_cnt++;

    spike_encoder dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_image_buffer(i_image_buffer),
        .i_image_valid(i_image_valid),
        .i_encode_start(i_encode_start),
        .i_spike_ready(i_spike_ready),
        .o_spike_vec(o_spike_vec),
        .o_spike_valid(o_spike_valid),
        .o_timestep(o_timestep),
        .o_encode_busy(o_encode_busy),
        .o_encode_done(o_encode_done)
    );

    task automatic chk(input string tag, input wide_t got, input wide_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < L; j++) mdl_lfsr[j] = (SEED + j) & 16'hFFFF;
        for (int n = 0; n < N; n++) mdl_img[n] = 8'd0;
    endtask

    // Raster pixel n lands on lane n%L; each lane steps once per pixel it codes.
    task automatic model_frame(output wide_t f);
        int lane, fb;
        f = '0;
        for (int n = 0; n < N; n++) begin
            lane = n % L;
            f[N-1-n] = (int'(mdl_img[n]) > (mdl_lfsr[lane] & 255));
            fb = (mdl_lfsr[lane] ^ (mdl_lfsr[lane] >> 2) ^
                  (mdl_lfsr[lane] >> 3) ^ (mdl_lfsr[lane] >> 5)) & 1;
            mdl_lfsr[lane] = (mdl_lfsr[lane] >> 1) | (fb << 15);
        end
    endtask

    task automatic load_img();
        for (int n = 0; n < N; n++) i_image_buffer[N-1-n] = mdl_img[n];
        i_image_valid = 1'b1;
        @(posedge clk); #1;
        i_image_valid = 1'b0;
    endtask

    task automatic run_check(input string tag, input int stall_ts,
                             input bit inject, output wide_t f0);
        wide_t exp_f, prev_vec, sv;
        int cnt, d0;
        bit stable;
        d0 = done_cnt;
        f0 = '0;
`ifdef SPIKE_ENCODER_RESEED_EN
        for (int j = 0; j < L; j++) mdl_lfsr[j] = (SEED + j) & 16'hFFFF;
`endif
        i_spike_ready = 1'b1;
        i_encode_start = 1'b1;
        @(posedge clk); #1;
        i_encode_start = 1'b0;
        chk({tag, "_busy_set"}, wide_t'(o_encode_busy), wide_t'(1));
        for (int t = 0; t < T; t++) begin
            model_frame(exp_f);
            prev_vec = o_spike_vec;
            stable = 1'b1;
            cnt = 0;
            if (t == stall_ts) i_spike_ready = 1'b0;
            while (!o_spike_valid && cnt < 200) begin
                if (inject && t == 1 && cnt == 10) begin
                    for (int n = 0; n < N; n++) i_image_buffer[n] = 8'($urandom);
                    i_image_valid = 1'b1;
                    i_encode_start = 1'b1;
                end else if (inject && t == 1 && cnt == 11) begin
                    i_image_valid = 1'b0;
                    i_encode_start = 1'b0;
                end
                @(posedge clk); #1;
                cnt++;
                if (!o_spike_valid && o_spike_vec !== prev_vec) stable = 1'b0;
            end
            chk($sformatf("%s_t%0d_latency", tag, t), wide_t'(cnt), wide_t'(LAT));
            chk($sformatf("%s_t%0d_vec_hold", tag, t), wide_t'(stable), wide_t'(1));
            chk($sformatf("%s_t%0d_frame", tag, t), o_spike_vec, exp_f);
            chk($sformatf("%s_t%0d_ts", tag, t), wide_t'(o_timestep), wide_t'(t));
            if (t == 0) f0 = o_spike_vec;
            if (t == stall_ts) begin
                sv = o_spike_vec;
                stable = 1'b1;
                repeat (20) begin
                    @(posedge clk); #1;
                    if (o_spike_vec !== sv || o_timestep !== 4'(t) ||
                        o_spike_valid !== 1'b1) stable = 1'b0;
                end
                chk({tag, "_stall_hold"}, wide_t'(stable), wide_t'(1));
                i_spike_ready = 1'b1;
            end
            @(posedge clk); #1;
            chk($sformatf("%s_t%0d_valid_clr", tag, t),
                wide_t'(o_spike_valid), wide_t'(0));
        end
        chk({tag, "_done_early"}, wide_t'(o_encode_done), wide_t'(0));
        chk({tag, "_busy_in_done"}, wide_t'(o_encode_busy), wide_t'(1));
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, wide_t'(o_encode_done), wide_t'(1));
        chk({tag, "_busy_clr"}, wide_t'(o_encode_busy), wide_t'(0));
        @(posedge clk); #1;
        chk({tag, "_done_low"}, wide_t'(o_encode_done), wide_t'(0));
        chk({tag, "_done_count"}, wide_t'(done_cnt - d0), wide_t'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_vec"}, o_spike_vec, '0);
        chk({tag, "_valid"}, wide_t'(o_spike_valid), wide_t'(0));
        chk({tag, "_ts"}, wide_t'(o_timestep), wide_t'(0));
        chk({tag, "_busy"}, wide_t'(o_encode_busy), wide_t'(0));
        chk({tag, "_done"}, wide_t'(o_encode_done), wide_t'(0));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wide_t f1, f2, fx;
        int d0;
        bit same;
        model_reset();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("por");

        run_check("zero", -1, 1'b0, fx);

        for (int n = 0; n < N; n++) mdl_img[n] = 8'(n % 256);
        load_img();
        run_check("ramp", -1, 1'b0, fx);

        for (int n = 0; n < N; n++) mdl_img[n] = 8'($urandom);
        load_img();
        run_check("rnd_stall", 3, 1'b1, fx);

        for (int n = 0; n < N; n++) mdl_img[n] = 8'($urandom);
        load_img();
        run_check("b2b1", -1, 1'b0, f1);
        run_check("b2b2", -1, 1'b0, f2);
`ifdef SPIKE_ENCODER_RESEED_EN
        same = 1'b1;
`else
        same = 1'b0;
`endif
        chk("b2b_same_frame0", wide_t'(f1 == f2), wide_t'(same));

        i_spike_ready = 1'b1;
        i_encode_start = 1'b1;
        @(posedge clk); #1;
        i_encode_start = 1'b0;
        repeat (5 * (LAT + 1) + 40) @(posedge clk);
        #1;
        chk("pre_rst_ts", wide_t'(o_timestep), wide_t'(5));
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_rst");
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_reset_outputs("post_rst");
        chk("rst_no_done", wide_t'(done_cnt - d0), wide_t'(0));
        model_reset();
        for (int n = 0; n < N; n++) mdl_img[n] = 8'($urandom);
        load_img();
        run_check("rerun", -1, 1'b0, fx);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
